// File: rtl/div_share_arb.sv
// Shared signed divider with two round-robin requesters and one valid/ready response port.
// Restoring shift-subtract over W cycles on magnitudes, then sign fix-up.
module div_share_arb #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_dz,
  output logic         rsp_ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_last;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_dvd;
  logic [W-1:0]   r_dvs;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic           r_sa;
  logic           r_sq;
  logic           r_id;
  logic           r_ovf;
  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic [W-1:0]   r_rsp_q;
  logic [W-1:0]   r_rsp_r;
  logic           r_rsp_dz;
  logic           r_rsp_ovf;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_acc;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_dz;
  logic           w_ovf;
  logic [W:0]     w_shift;
  logic           w_ge;
  logic [W-1:0]   w_diff;

  // Unsigned magnitude of a two's complement value; the most-negative value maps to 2^(W-1).
  function automatic logic [W-1:0] f_mag(input logic [W-1:0] v);
    if (v[W-1]) begin
      return ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  function automatic logic [W-1:0] f_neg(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Grant selection, operand mux and one restoring-division step.
  always_comb begin
    w_gnt0  = rst_n && (r_state == IDLE) && req0_valid && (!req1_valid || r_last);
    w_gnt1  = rst_n && (r_state == IDLE) && req1_valid && (!req0_valid || !r_last);
    w_acc   = w_gnt0 || w_gnt1;
    w_sel_a = w_gnt1 ? req1_a : req0_a;
    w_sel_b = w_gnt1 ? req1_b : req0_b;
    w_mag_a = f_mag(w_sel_a);
    w_mag_b = f_mag(w_sel_b);
    w_dz    = (w_sel_b == {W{1'b0}});
    w_ovf   = (w_sel_a == {1'b1, {(W-1){1'b0}}}) && (w_sel_b == {W{1'b1}});
    // Partial remainder stays below |b| <= 2^(W-1), so the difference always fits W bits.
    w_shift = {r_rem, r_dvd[W-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift[W-1:0] - r_dvs;
  end

  // Scheduler FSM, datapath and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= {CW{1'b0}};
      r_dvd       <= {W{1'b0}};
      r_dvs       <= {W{1'b0}};
      r_rem       <= {W{1'b0}};
      r_quo       <= {W{1'b0}};
      r_sa        <= 1'b0;
      r_sq        <= 1'b0;
      r_id        <= 1'b0;
      r_ovf       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_q     <= {W{1'b0}};
      r_rsp_r     <= {W{1'b0}};
      r_rsp_dz    <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_id   <= w_gnt1;
            r_last <= w_gnt1;
            r_dvd  <= w_mag_a;
            r_dvs  <= w_mag_b;
            r_rem  <= {W{1'b0}};
            r_quo  <= {W{1'b0}};
            r_sa   <= w_sel_a[W-1];
            r_sq   <= w_sel_a[W-1] ^ w_sel_b[W-1];
            r_ovf  <= w_ovf;
            r_cnt  <= {CW{1'b0}};
            if (w_dz) begin
              // Result is known now; DONE raises rsp_valid on the following edge.
              r_rsp_id  <= w_gnt1;
              r_rsp_q   <= {W{1'b0}};
              r_rsp_r   <= w_sel_a;
              r_rsp_dz  <= 1'b1;
              r_rsp_ovf <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_shift[W-1:0];
          r_quo <= {r_quo[W-2:0], w_ge};
          r_dvd <= {r_dvd[W-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) begin
            r_state <= FIX;
          end else begin
            r_state <= CALC;
          end
        end
        FIX: begin
          // Most-negative / -1 wraps naturally: magnitude 2^(W-1) with positive sign.
          r_rsp_q     <= r_sq ? f_neg(r_quo) : r_quo;
          r_rsp_r     <= r_sa ? f_neg(r_rem) : r_rem;
          r_rsp_id    <= r_id;
          r_rsp_dz    <= 1'b0;
          r_rsp_ovf   <= r_ovf;
          r_rsp_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_q      = r_rsp_q;
  assign rsp_r      = r_rsp_r;
  assign rsp_dz     = r_rsp_dz;
  assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_div_share_arb.sv
// Scoreboard bench for div_share_arb: directed edge cases, arbitration, backpressure,
// async reset and a randomized sweep against an arithmetic reference model.
module tb_div_share_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_dz, rsp_ovf;
  logic [W-1:0] rsp_q, rsp_r;

  always #5 clk = ~clk;

  div_share_arb #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   hs_edge[$];
  logic hs_id[$];
  int   n_chk = 0, n_err = 0, cyc = 0, n_acc = 0;
  logic busy = 1'b0, m_last = 1'b1, seen = 1'b0;
  logic m_e0, m_e1;
  exp_t m_e;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain integer division truncating toward zero plus the two special cases.
  function automatic exp_t ref_div(input logic id, input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b, input int acc);
    exp_t e;
    int ia, ib;
    ia = a;
    ib = b;
    e.id = id; e.acc = acc; e.dz = 1'b0; e.ovf = 1'b0;
    if (ib == 0) begin
      e.q = '0; e.r = a; e.dz = 1'b1;
    end else if (ia == -(2 ** (W - 1)) && ib == -1) begin
      e.q = a; e.r = '0; e.ovf = 1'b1;
    end else begin
      e.q = W'(ia / ib);
      e.r = W'(ia % ib);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0: return {1'b1, {(W-1){1'b0}}};
      1: return '0;
      2: return '1;
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: grant model, acceptance into the scoreboard, response comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_ctl", int'({rsp_valid, rsp_id, rsp_dz, rsp_ovf, req0_ready, req1_ready}), 0);
      check("reset_q", int'(rsp_q), 0);
      check("reset_r", int'(rsp_r), 0);
    end else begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        hs_edge.push_back(cyc + 1);
        hs_id.push_back(req1_ready);
      end
      if (busy) begin
        check("ready_busy", int'({req0_ready, req1_ready}), 0);
      end else begin
        m_e0 = req0_valid && (!req1_valid || m_last);
        m_e1 = req1_valid && (!req0_valid || !m_last);
        check("grant", int'({req0_ready, req1_ready}), int'({m_e0, m_e1}));
        if (m_e0 || m_e1) begin
          exp_q.push_back(ref_div(m_e1, m_e1 ? req1_a : req0_a, m_e1 ? req1_b : req0_b, cyc + 1));
          m_last = m_e1;
          busy = 1'b1;
          n_acc++;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (t=%0t)", $time);
        end else begin
          m_e = exp_q[0];
          check("rsp_id", int'(rsp_id), int'(m_e.id));
          check("rsp_q", int'(rsp_q), int'(m_e.q));
          check("rsp_r", int'(rsp_r), int'(m_e.r));
          check("rsp_dz", int'(rsp_dz), int'(m_e.dz));
          check("rsp_ovf", int'(rsp_ovf), int'(m_e.ovf));
          if (!seen) begin
            check("latency", cyc - m_e.acc, m_e.dz ? 1 : W + 1);
            seen = 1'b1;
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
            busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (n_acc < target && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_timeout", int'(n_acc >= target), 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic req(input logic id, input int a, input int b);
    int start;
    start = n_acc;
    if (id) begin
      req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b);
    end else begin
      req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b);
    end
    wait_acc(start + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int start, k;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // Directed operands on requester 0
    req(1'b0, 8, 4);     drain();
    req(1'b0, 7, 3);     drain();
    req(1'b0, -9, 2);    drain();
    req(1'b0, 7, -2);    drain();
    req(1'b0, -128, -1); drain();
    req(1'b0, -128, 1);  drain();
    req(1'b0, 5, 0);     drain();

    // Backpressure: both requesters pending while the response stalls
    rsp_ready = 1'b0;
    req(1'b0, 100, -7);
    req0_valid = 1'b1; req0_a = W'(3); req0_b = W'(1);
    req1_valid = 1'b1; req1_a = W'(9); req1_b = W'(2);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_valid_rise", int'(rsp_valid), 1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_release", int'(rsp_valid), 0);
    check("bp_popped", exp_q.size(), 0);
    drain();

    // Async reset in the middle of CALC drops the request
    req(1'b0, 100, 7);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = W'(50);  req0_b = W'(6);
    req1_valid = 1'b1; req1_a = W'(-77); req1_b = W'(5);
    #1;
    check("rst_async_ctl", int'({rsp_valid, rsp_id, rsp_dz, rsp_ovf, req0_ready, req1_ready}), 0);
    check("rst_async_qr", int'({rsp_q, rsp_r}), 0);
    exp_q.delete(); busy = 1'b0; m_last = 1'b1; seen = 1'b0;
    hs_edge.delete(); hs_id.delete();
    start = n_acc;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Arbitration with both requesters held valid
    wait_acc(start + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("arb_count", hs_id.size(), 4);
    if (hs_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("arb_id", int'(hs_id[i]), i % 2);
        if (i > 0) check("arb_spacing", hs_edge[i] - hs_edge[i-1], W + 3);
      end
    end

    // Random sweep from both requesters with random response backpressure
    start = n_acc;
    k = 0;
    while (n_acc < start + 1000 && k < 40000) begin
      req0_valid = ($urandom % 4) != 0; req0_a = rnd_op(); req0_b = rnd_op();
      req1_valid = ($urandom % 4) != 0; req1_a = rnd_op(); req1_b = rnd_op();
      rsp_ready  = $urandom % 2;
      @(posedge clk); #1;
      k++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    check("sweep_count", int'(n_acc - start >= 1000), 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
